// File: rtl/rtc_init_pkg.sv
// Shared definitions for the RTC initialisation sequencer: write table,
// entry layout and FSM state encoding.
package rtc_init_pkg;

    localparam int NUM_INIT_WRITES = 4;
    localparam int IDX_W           = $clog2(NUM_INIT_WRITES);

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_entry_t;

    // Entry 0 sits in the least significant slot: init bit set, init bit clear,
    // 24 h mode / control, transfer command.
    localparam logic [NUM_INIT_WRITES-1:0][15:0] INIT_TABLE = {
        16'hF1_00,
        16'h10_D2,
        16'h02_00,
        16'h02_10
    };

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_SETTLE    = 3'd1;
    localparam state_t ST_ISSUE     = 3'd2;
    localparam state_t ST_WAIT_DONE = 3'd3;
    localparam state_t ST_DONE      = 3'd4;
    localparam state_t ST_ERROR     = 3'd5;

endpackage

// File: rtl/rtc_init_sequencer_rom.sv
// Combinational index -> {addr, data} lookup into the init write table.
module rtc_init_rom
    import rtc_init_pkg::*;
(
    input  logic [IDX_W-1:0] index,
    output logic [7:0]       addr,
    output logic [7:0]       data
);

    wr_entry_t entry_s;

    // Index is full-range for the table, so every code selects a valid entry
    always_comb begin
        entry_s = wr_entry_t'(INIT_TABLE[index]);
    end

    assign addr = entry_s.addr;
    assign data = entry_s.data;

endmodule

// File: rtl/rtc_init_sequencer.sv
// RTC initialisation sequencer: settle delay, then a fixed list of register
// writes through the bus write driver with timeout/retry, then finint.
module rtc_init_sequencer
    import rtc_init_pkg::*;
#(
    parameter int WAIT_CYCLES    = 100,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int MAX_RETRY      = 3
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       wr_done,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       finint,
    output logic       init_err
);

    localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_INIT_WRITES - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_nxt_s;
    logic [RTY_W-1:0]  retry_r;
    logic [RTY_W-1:0]  retry_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_nxt_s;

    logic              wait_end_s;
    logic              timeout_s;
    logic [7:0]        rom_addr_s;
    logic [7:0]        rom_data_s;

    logic              wr_req_r;
    logic              wr_req_nxt_s;
    logic [7:0]        wr_addr_r;
    logic [7:0]        wr_data_r;
    logic              finint_r;
    logic              finint_nxt_s;
    logic              init_err_r;
    logic              init_err_nxt_s;

    assign wait_end_s = (wait_cnt_r == WAIT_LAST);
    assign timeout_s  = (tmo_cnt_r == TMO_LAST);

    // The table is addressed by the index that will be current in ISSUE
    rtc_init_rom u_rom (
        .index (idx_nxt_s),
        .addr  (rom_addr_s),
        .data  (rom_data_s)
    );

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an outstanding write is always allowed to finish before aborting
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (iniciar) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!iniciar) begin
                    state_nxt_s = ST_IDLE;
                end else if (wait_end_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_ISSUE: begin
                if (!iniciar) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (wr_done) begin
                    if (!iniciar) begin
                        state_nxt_s = ST_IDLE;
                    end else if (idx_r == IDX_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else if (timeout_s) begin
                    if (!iniciar) begin
                        state_nxt_s = ST_IDLE;
                    end else if (retry_r == RTY_MAX) begin
                        state_nxt_s = ST_ERROR;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!iniciar) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Saturating counters and write index
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        tmo_cnt_nxt_s  = tmo_cnt_r;
        retry_nxt_s    = retry_r;
        idx_nxt_s      = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (iniciar) begin
                    wait_cnt_nxt_s = WAIT_W'(0);
                    retry_nxt_s    = RTY_W'(0);
                    idx_nxt_s      = IDX_W'(0);
                end else begin
                    idx_nxt_s      = idx_r;
                end
            end
            ST_SETTLE: begin
                if (!wait_end_s) begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_nxt_s = TMO_W'(0);
            end
            ST_WAIT_DONE: begin
                if (tmo_cnt_r != TMO_MAX) begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r;
                end
                if ((state_nxt_s == ST_ISSUE) && wr_done) begin
                    retry_nxt_s = RTY_W'(0);
                    if (idx_r != IDX_LAST) begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end else begin
                        idx_nxt_s = idx_r;
                    end
                end else if (state_nxt_s == ST_ISSUE) begin
                    if (retry_r != RTY_MAX) begin
                        retry_nxt_s = retry_r + RTY_W'(1);
                    end else begin
                        retry_nxt_s = retry_r;
                    end
                end else begin
                    retry_nxt_s = retry_r;
                end
            end
            default: begin
                idx_nxt_s = idx_r;
            end
        endcase
    end

    // Output decode: values every output register takes at the next edge
    always_comb begin
        wr_req_nxt_s   = (state_nxt_s == ST_ISSUE);
        finint_nxt_s   = (state_nxt_s == ST_DONE);
        init_err_nxt_s = init_err_r;
        if (state_nxt_s == ST_ERROR) begin
            init_err_nxt_s = 1'b1;
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_SETTLE)) begin
            init_err_nxt_s = 1'b0;
        end else begin
            init_err_nxt_s = init_err_r;
        end
    end

    // Counter, index and output registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= WAIT_W'(0);
            tmo_cnt_r  <= TMO_W'(0);
            retry_r    <= RTY_W'(0);
            idx_r      <= IDX_W'(0);
            wr_req_r   <= 1'b0;
            wr_addr_r  <= 8'h00;
            wr_data_r  <= 8'h00;
            finint_r   <= 1'b0;
            init_err_r <= 1'b0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
            tmo_cnt_r  <= tmo_cnt_nxt_s;
            retry_r    <= retry_nxt_s;
            idx_r      <= idx_nxt_s;
            wr_req_r   <= wr_req_nxt_s;
            finint_r   <= finint_nxt_s;
            init_err_r <= init_err_nxt_s;
            if (wr_req_nxt_s) begin
                wr_addr_r <= rom_addr_s;
                wr_data_r <= rom_data_s;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    assign wr_req   = wr_req_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign finint   = finint_r;
    assign init_err = init_err_r;

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Directed bench for rtc_init_sequencer with a request scoreboard and a
// bus-driver model that can withhold wr_done for chosen entries.
module tb_rtc_init_sequencer;

    localparam int WAIT_CYCLES    = 4;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int MAX_RETRY      = 3;

    logic       CLK;
    logic       reset;
    logic       iniciar;
    logic       wr_done;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       finint;
    logic       init_err;

    logic       resp_done;
    logic       resp_next;
    logic       stray_done;
    logic       prev_req;
    logic       finint_seen;

    int         pass_cnt;
    int         total_cnt;
    int         req_count;
    int         neg_cnt;
    int         drop_cnt;
    logic [15:0] drop_pair;

    logic [15:0] sb_q[$];
    int          req_stamp[$];
    logic [15:0] tab [4];

    rtc_init_sequencer #(
        .WAIT_CYCLES    (WAIT_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRY      (MAX_RETRY)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .iniciar  (iniciar),
        .wr_done  (wr_done),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .finint   (finint),
        .init_err (init_err)
    );

    assign wr_done = resp_done | stray_done;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic push_entry(input int e);
        sb_q.push_back(tab[e]);
    endtask

    task automatic wait_finint(output int n, input int limit);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!finint && n < limit);
    endtask

    // Bus-driver model and request monitor; answers one cycle after each wr_req
    always @(negedge CLK) begin
        resp_done = resp_next;
        resp_next = 1'b0;
        neg_cnt++;
        if (finint === 1'b1) finint_seen = 1'b1;
        if (wr_req === 1'b1) begin
            check("wr_req_back_to_back", 32'(prev_req), 32'd0);
            check("sb_has_expected", 32'(sb_q.size() != 0), 32'd1);
            req_count++;
            req_stamp.push_back(neg_cnt);
            if (sb_q.size() != 0) begin
                check("wr_addr_data", {16'd0, wr_addr, wr_data}, {16'd0, sb_q.pop_front()});
            end
            if (drop_cnt > 0 && {wr_addr, wr_data} == drop_pair) begin
                drop_cnt--;
            end else begin
                resp_next = 1'b1;
            end
        end
        prev_req = wr_req;
    end

    initial begin
        int n;
        int base;
        tab[0] = 16'h0210;
        tab[1] = 16'h0200;
        tab[2] = 16'h10D2;
        tab[3] = 16'hF100;
        pass_cnt    = 0;
        total_cnt   = 0;
        req_count   = 0;
        neg_cnt     = 0;
        drop_cnt    = 0;
        drop_pair   = 16'h0000;
        resp_done   = 1'b0;
        resp_next   = 1'b0;
        stray_done  = 1'b0;
        prev_req    = 1'b0;
        finint_seen = 1'b0;
        reset       = 1'b0;
        iniciar     = 1'b0;

        tick(3);
        check("rst_wr_req",   32'(wr_req),   32'd0);
        check("rst_wr_addr",  32'(wr_addr),  32'd0);
        check("rst_wr_data",  32'(wr_data),  32'd0);
        check("rst_finint",   32'(finint),   32'd0);
        check("rst_init_err", 32'(init_err), 32'd0);
        reset = 1'b1;
        tick(2);

        // Test 1: reset pulse while settling
        iniciar = 1'b1;
        tick(3);
        #2 reset = 1'b0;
        #1;
        check("t1_wr_req",   32'(wr_req),   32'd0);
        check("t1_finint",   32'(finint),   32'd0);
        check("t1_init_err", 32'(init_err), 32'd0);
        iniciar = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        check("t1_no_requests", 32'(req_count), 32'd0);

        // Test 2: nominal sequence, latency WAIT + 2*4 + 1
        for (int e = 0; e < 4; e++) push_entry(e);
        iniciar = 1'b1;
        wait_finint(n, 200);
        check("t2_latency", 32'(n), 32'(WAIT_CYCLES + 2 * 4 + 1));
        check("t2_all_issued", 32'(sb_q.size()), 32'd0);
        tick(3);
        check("t2_finint_held", 32'(finint), 32'd1);
        iniciar = 1'b0;
        tick(1);
        check("t2_finint_drop", 32'(finint), 32'd0);
        tick(3);

        // Test 3: entry 2 unanswered once -> one re-issue after the timeout
        base      = req_count;
        drop_pair = 16'h10D2;
        drop_cnt  = 1;
        push_entry(0); push_entry(1); push_entry(2); push_entry(2); push_entry(3);
        iniciar = 1'b1;
        wait_finint(n, 300);
        check("t3_finint", 32'(finint), 32'd1);
        check("t3_init_err", 32'(init_err), 32'd0);
        check("t3_req_total", 32'(req_count - base), 32'd5);
        // 8 silent wait cycles, re-issue in the following one
        if (req_count - base >= 4) begin
            check("t3_retry_gap", 32'(req_stamp[base + 3] - req_stamp[base + 2]),
                  32'(TIMEOUT_CYCLES + 1));
        end
        iniciar = 1'b0;
        tick(3);

        // Test 4: entry 0 never answered -> 1 + MAX_RETRY requests, then error
        base      = req_count;
        drop_pair = 16'h0210;
        drop_cnt  = 1000;
        for (int i = 0; i <= MAX_RETRY; i++) push_entry(0);
        iniciar = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!init_err && n < 300);
        check("t4_init_err", 32'(init_err), 32'd1);
        check("t4_finint", 32'(finint), 32'd0);
        check("t4_req_total", 32'(req_count - base), 32'(MAX_RETRY + 1));
        tick(30);
        check("t4_no_more_req", 32'(req_count - base), 32'(MAX_RETRY + 1));
        iniciar = 1'b0;
        tick(2);
        check("t4_err_sticky", 32'(init_err), 32'd1);
        drop_cnt = 0;
        tick(2);

        // Test 5: iniciar dropped while waiting on entry 1
        base        = req_count;
        finint_seen = 1'b0;
        push_entry(0); push_entry(1);
        iniciar = 1'b1;
        tick(2);
        check("t5_err_cleared", 32'(init_err), 32'd0);
        n = 0;
        while (req_count - base < 2 && n < 200) begin
            tick(1);
            n++;
        end
        tick(1);
        iniciar = 1'b0;
        tick(20);
        check("t5_req_total", 32'(req_count - base), 32'd2);
        check("t5_finint_never", 32'(finint_seen), 32'd0);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Test 6: stray wr_done in SETTLE is ignored
        for (int e = 0; e < 4; e++) push_entry(e);
        iniciar = 1'b1;
        tick(2);
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        n = n + 0;
        wait_finint(n, 200);
        check("t6_latency", 32'(n + 3), 32'(WAIT_CYCLES + 2 * 4 + 1));
        check("t6_all_issued", 32'(sb_q.size()), 32'd0);
        // Asynchronous reset clears outputs without waiting for a clock edge
        #2 reset = 1'b0;
        #1;
        check("t6_async_finint", 32'(finint), 32'd0);
        check("t6_async_addr", 32'(wr_addr), 32'd0);
        check("t6_async_data", 32'(wr_data), 32'd0);
        iniciar = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
